// File: rtl/acq_readout_ctrl.sv
// Acquisition trigger and sample-RAM readout sequencer. It streams the enabled channel bytes of each sample.
// Optional build macro READOUT_HEADER_EN inserts a two-byte header (0xA5, {mask,4'b0000}) before the first sample.
module acq_readout_ctrl #(
    parameter int RAM_WIDTH = 10,
    parameter int NCHAN     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_arm,
    input  logic                 i_abort,
    input  logic [NCHAN-1:0]     i_chan_mask,
    output logic                 o_start_trigger,
    input  logic                 i_data_ready,
    input  logic [RAM_WIDTH-1:0] i_wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] i_triggerpoint,
    input  logic [RAM_WIDTH-1:0] i_nsmp,
    output logic                 o_rden,
    output logic [RAM_WIDTH-1:0] o_rdaddress,
    input  logic [31:0]          i_ram_q,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_FETCH    = 3'd3,
        S_LATCH    = 3'd4,
        S_SEND     = 3'd5,
        S_DONE     = 3'd6
`ifdef READOUT_HEADER_EN
        , S_HDR    = 3'd7
`endif
    } state_t;

    function automatic logic [1:0] first_chan(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Bit 2 flags that a higher enabled channel exists; bits [1:0] give its index.
    function automatic logic [2:0] next_chan(input logic [3:0] m, input logic [1:0] p);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(p))) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic [7:0] chan_byte(input logic [31:0] w, input logic [1:0] c);
        logic [7:0] b;
        case (c)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t               r_state;
    logic                 r_start_trigger;
    logic                 r_rden;
    logic [RAM_WIDTH-1:0] r_rdaddress;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_mask;
    logic [RAM_WIDTH-1:0] r_base;
    logic [RAM_WIDTH-1:0] r_count;
    logic [RAM_WIDTH-1:0] r_nsmp;
    logic [31:0]          r_buf;
    logic [1:0]           r_ptr;
`ifdef READOUT_HEADER_EN
    logic                 r_first;
    logic                 r_hdr_idx;
`endif

    logic [RAM_WIDTH-1:0] w_base;
    logic [RAM_WIDTH-1:0] w_count_inc;
    logic [2:0]           w_next;

    assign w_base      = i_wraddress_triggerpoint - i_triggerpoint;
    assign w_count_inc = r_count + RAM_WIDTH'(1);
    assign w_next      = next_chan(r_mask, r_ptr);

    assign o_start_trigger = r_start_trigger;
    assign o_rden          = r_rden;
    assign o_rdaddress     = r_rdaddress;
    assign o_tx_data       = r_tx_data;
    assign o_tx_valid      = r_tx_valid;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

    // Readout sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state         <= S_IDLE;
            r_start_trigger <= 1'b0;
            r_rden          <= 1'b0;
            r_rdaddress     <= '0;
            r_tx_data       <= 8'h00;
            r_tx_valid      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_mask          <= 4'h0;
            r_base          <= '0;
            r_count         <= '0;
            r_nsmp          <= '0;
            r_buf           <= 32'h0000_0000;
            r_ptr           <= 2'd0;
`ifdef READOUT_HEADER_EN
            r_first         <= 1'b0;
            r_hdr_idx       <= 1'b0;
`endif
        end else if (i_abort) begin
            r_state         <= S_IDLE;
            r_start_trigger <= 1'b0;
            r_rden          <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_arm && (i_chan_mask != 4'h0)) begin
                        r_state         <= S_ARM;
                        r_mask          <= i_chan_mask;
                        r_start_trigger <= 1'b1;
                        r_busy          <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (!i_data_ready) begin
                        r_state         <= S_WAIT_RDY;
                        r_start_trigger <= 1'b0;
                    end
                end
                S_WAIT_RDY: begin
                    if (i_data_ready) begin
                        r_state     <= S_FETCH;
                        r_base      <= w_base;
                        r_nsmp      <= i_nsmp;
                        r_count     <= '0;
                        r_rden      <= 1'b1;
                        r_rdaddress <= w_base;
`ifdef READOUT_HEADER_EN
                        r_first     <= 1'b1;
`endif
                    end
                end
                S_FETCH: begin
                    r_state <= S_LATCH;
                    r_rden  <= 1'b0;
                end
                S_LATCH: begin
                    r_buf      <= i_ram_q;
                    r_ptr      <= first_chan(r_mask);
                    r_tx_valid <= 1'b1;
`ifdef READOUT_HEADER_EN
                    if (r_first) begin
                        r_state   <= S_HDR;
                        r_first   <= 1'b0;
                        r_hdr_idx <= 1'b0;
                        r_tx_data <= 8'hA5;
                    end else begin
                        r_state   <= S_SEND;
                        r_tx_data <= chan_byte(i_ram_q, first_chan(r_mask));
                    end
`else
                    r_state   <= S_SEND;
                    r_tx_data <= chan_byte(i_ram_q, first_chan(r_mask));
`endif
                end
`ifdef READOUT_HEADER_EN
                S_HDR: begin
                    if (i_tx_ready) begin
                        if (!r_hdr_idx) begin
                            r_hdr_idx <= 1'b1;
                            r_tx_data <= {r_mask, 4'b0000};
                        end else begin
                            r_state   <= S_SEND;
                            r_tx_data <= chan_byte(r_buf, r_ptr);
                        end
                    end
                end
`endif
                S_SEND: begin
                    if (i_tx_ready) begin
                        if (w_next[2]) begin
                            r_ptr     <= w_next[1:0];
                            r_tx_data <= chan_byte(r_buf, w_next[1:0]);
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_count    <= w_count_inc;
                            // nsmp==0 matches only after the counter wraps, i.e. a full RAM of samples.
                            if (w_count_inc == r_nsmp) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= S_FETCH;
                                r_rden      <= 1'b1;
                                r_rdaddress <= r_base + w_count_inc;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_start_trigger <= 1'b0;
                    r_rden          <= 1'b0;
                    r_tx_valid      <= 1'b0;
                    r_busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
